output_neuron_accumulator: RTL and testbench



---
 rtl/output_neuron_accumulator.sv | 148 ++++++++++++++
 tb/tb_output_neuron_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/output_neuron_accumulator.sv
// Multiply-accumulates one filter window of neuron/weight taps, then adds bias,
// scales, applies ReLU and saturation, and offers one 8-bit result per window.
module output_neuron_accumulator #(
    parameter int DATA_W = 8,
    parameter int BIAS_W = 16,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 0,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     layer_reset_n,
    input  logic [2:0]               filter_width_i,
    input  logic                     ac_en_i,
    input  logic signed [DATA_W-1:0] neuron_i,
    input  logic signed [DATA_W-1:0] weight_i,
    input  logic signed [BIAS_W-1:0] bias_i,
    output logic [7:0]               result_o,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         result_count_o
);

    localparam int PROD_W = 2 * DATA_W;

    // Index of the final tap for a (fw+1)x(fw+1) window; 8x8 wraps 64 to 0 then back to 63.
    function automatic logic [5:0] lastIndexOf(input logic [2:0] fw);
        logic [5:0] side;
        side = {3'b000, fw} + 6'd1;
        return (side * side) - 6'd1;
    endfunction

    logic [5:0]               tapCnt_q, tapCnt_d;
    logic [5:0]               lastIdx_q, lastIdx_d;
    logic                     s1Valid_q, s1Valid_d;
    logic                     s1First_q, s1First_d;
    logic                     s1Last_q, s1Last_d;
    logic signed [PROD_W-1:0] s1Prod_q, s1Prod_d;
    logic signed [BIAS_W-1:0] s1Bias_q, s1Bias_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     s2Valid_q, s2Valid_d;
    logic signed [ACC_W-1:0]  s2Sum_q, s2Sum_d;
    logic [7:0]               result_q, result_d;
    logic                     valid_q, valid_d;
    logic                     overflow_q, overflow_d;
    logic [CNT_W-1:0]         count_q, count_d;

    logic                     firstTap;
    logic                     lastTap;
    logic [5:0]               curLastIdx;
    logic signed [ACC_W-1:0]  accSum;
    logic signed [ACC_W-1:0]  shifted;
    logic [7:0]               saturated;
    logic                     transfer;

    always_comb begin
        tapCnt_d   = tapCnt_q;
        lastIdx_d  = lastIdx_q;
        firstTap   = (tapCnt_q == 6'd0);
        curLastIdx = firstTap ? lastIndexOf(filter_width_i) : lastIdx_q;
        lastTap    = (tapCnt_q == curLastIdx);
        if (ac_en_i) begin
            lastIdx_d = curLastIdx;
            tapCnt_d  = lastTap ? 6'd0 : tapCnt_q + 6'd1;
        end

        s1Valid_d = ac_en_i;
        s1First_d = firstTap;
        s1Last_d  = ac_en_i && lastTap;
        s1Prod_d  = neuron_i * weight_i;
        s1Bias_d  = (ac_en_i && lastTap) ? bias_i : s1Bias_q;

        accSum    = (s1First_q ? '0 : acc_q)
                  + {{(ACC_W-PROD_W){s1Prod_q[PROD_W-1]}}, s1Prod_q};
        acc_d     = s1Valid_q ? accSum : acc_q;
        s2Valid_d = s1Valid_q && s1Last_q;
        s2Sum_d   = s2Valid_d ? accSum + {{(ACC_W-BIAS_W){s1Bias_q[BIAS_W-1]}}, s1Bias_q}
                              : s2Sum_q;

        // Negative clamps to 0 (ReLU); anything above 127 saturates.
        shifted = s2Sum_q >>> SHIFT;
        if (shifted[ACC_W-1]) begin
            saturated = 8'd0;
        end else if (|shifted[ACC_W-2:7]) begin
            saturated = 8'd127;
        end else begin
            saturated = {1'b0, shifted[6:0]};
        end

        transfer   = valid_q && result_ready_i;
        result_d   = result_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        count_d    = transfer ? count_q + 1'b1 : count_q;
        if (s2Valid_q) begin
            if (!valid_q || transfer) begin
                result_d = saturated;
                valid_d  = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!layer_reset_n) begin
            tapCnt_q   <= '0;
            lastIdx_q  <= '0;
            s1Valid_q  <= 1'b0;
            s1First_q  <= 1'b0;
            s1Last_q   <= 1'b0;
            s1Prod_q   <= '0;
            s1Bias_q   <= '0;
            acc_q      <= '0;
            s2Valid_q  <= 1'b0;
            s2Sum_q    <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            tapCnt_q   <= tapCnt_d;
            lastIdx_q  <= lastIdx_d;
            s1Valid_q  <= s1Valid_d;
            s1First_q  <= s1First_d;
            s1Last_q   <= s1Last_d;
            s1Prod_q   <= s1Prod_d;
            s1Bias_q   <= s1Bias_d;
            acc_q      <= acc_d;
            s2Valid_q  <= s2Valid_d;
            s2Sum_q    <= s2Sum_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign overflow_o     = overflow_q;
    assign result_count_o = count_q;
    assign busy_o         = (tapCnt_q != 6'd0) || s1Valid_q || s2Valid_q;

endmodule

// File: tb/tb_output_neuron_accumulator.sv
// Directed bench driving two accumulators (SHIFT=0 and SHIFT=2) from the same
// stimulus, with a per-cycle vector table plus hand-written handshake/reset sequences.
module tb_output_neuron_accumulator;

    logic              clk = 1'b0;
    logic              layer_reset_n;
    logic [2:0]        filter_width_i;
    logic              ac_en_i;
    logic signed [7:0] neuron_i;
    logic signed [7:0] weight_i;
    logic signed [15:0] bias_i;
    logic              result_ready_i;

    logic [7:0]  result0, result2;
    logic        valid0, valid2;
    logic        busy0, busy2;
    logic        ovf0, ovf2;
    logic [15:0] count0, count2;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    output_neuron_accumulator #(.SHIFT(0)) dut0 (
        .clk(clk), .layer_reset_n(layer_reset_n), .filter_width_i(filter_width_i),
        .ac_en_i(ac_en_i), .neuron_i(neuron_i), .weight_i(weight_i), .bias_i(bias_i),
        .result_o(result0), .result_valid_o(valid0), .result_ready_i(result_ready_i),
        .busy_o(busy0), .overflow_o(ovf0), .result_count_o(count0)
    );

    output_neuron_accumulator #(.SHIFT(2)) dut2 (
        .clk(clk), .layer_reset_n(layer_reset_n), .filter_width_i(filter_width_i),
        .ac_en_i(ac_en_i), .neuron_i(neuron_i), .weight_i(weight_i), .bias_i(bias_i),
        .result_o(result2), .result_valid_o(valid2), .result_ready_i(result_ready_i),
        .busy_o(busy2), .overflow_o(ovf2), .result_count_o(count2)
    );

    typedef struct {
        logic              rstN;
        logic [2:0]        fw;
        logic              acEn;
        logic signed [7:0] n;
        logic signed [7:0] w;
        logic signed [15:0] b;
        logic              ready;
        logic              expValid;
        int                exp0;
        int                exp2;
        int                expCount;
        logic              expOvf;
        logic              expBusy;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic rstN, input logic [2:0] fw, input logic acEn,
                                   input int n, input int w, input int b, input logic ready,
                                   input logic expValid, input int exp0, input int exp2,
                                   input int expCount, input logic expOvf, input logic expBusy);
        vec_t v;
        v.rstN = rstN; v.fw = fw; v.acEn = acEn;
        v.n = 8'(n); v.w = 8'(w); v.b = 16'(b); v.ready = ready;
        v.expValid = expValid; v.exp0 = exp0; v.exp2 = exp2;
        v.expCount = expCount; v.expOvf = expOvf; v.expBusy = expBusy;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the rising edge take them, then settle.
    task automatic applyStimulus(input logic rstN, input logic [2:0] fw, input logic acEn,
                                 input int n, input int w, input int b, input logic ready);
        layer_reset_n  = rstN;
        filter_width_i = fw;
        ac_en_i        = acEn;
        neuron_i       = 8'(n);
        weight_i       = 8'(w);
        bias_i         = 16'(b);
        result_ready_i = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expValid, input int exp0,
                               input int exp2, input int expCount, input logic expOvf,
                               input logic expBusy);
        cmp({name, ".valid0"}, 32'(valid0), 32'(expValid));
        cmp({name, ".valid2"}, 32'(valid2), 32'(expValid));
        cmp({name, ".count0"}, 32'(count0), 32'(expCount));
        cmp({name, ".count2"}, 32'(count2), 32'(expCount));
        cmp({name, ".ovf0"}, 32'(ovf0), 32'(expOvf));
        cmp({name, ".ovf2"}, 32'(ovf2), 32'(expOvf));
        cmp({name, ".busy0"}, 32'(busy0), 32'(expBusy));
        cmp({name, ".busy2"}, 32'(busy2), 32'(expBusy));
        if (expValid) begin
            cmp({name, ".result0"}, 32'(result0), 32'(exp0));
            cmp({name, ".result2"}, 32'(result2), 32'(exp2));
        end
    endtask

    task automatic step(input string name, input logic rstN, input logic [2:0] fw,
                        input logic acEn, input int n, input int w, input int b,
                        input logic ready, input logic expValid, input int exp0,
                        input int exp2, input int expCount, input logic expOvf,
                        input logic expBusy);
        applyStimulus(rstN, fw, acEn, n, w, b, ready);
        checkOutput(name, expValid, exp0, exp2, expCount, expOvf, expBusy);
    endtask

    initial begin
        layer_reset_n  = 1'b0;
        filter_width_i = 3'd0;
        ac_en_i        = 1'b0;
        neuron_i       = '0;
        weight_i       = '0;
        bias_i         = '0;
        result_ready_i = 1'b0;

        // rst fw ac n w b rdy | valid res0 res2 count ovf busy
        addVec(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        // 1x1 window 3*4: 12 unshifted, 3 after >>>2
        addVec(1, 0, 1, 3, 4, 0, 0,   0, 0, 0, 0, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 0,   1, 12, 3, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 0);
        // 2x2 window of 10*10, sum 400: saturates to 127, 100 after >>>2
        addVec(1, 1, 1, 10, 10, 0, 1, 0, 0, 0, 1, 0, 1);
        addVec(1, 1, 1, 10, 10, 0, 1, 0, 0, 0, 1, 0, 1);
        addVec(1, 1, 1, 10, 10, 0, 1, 0, 0, 0, 1, 0, 1);
        addVec(1, 1, 1, 10, 10, 0, 1, 0, 0, 0, 1, 0, 1);
        addVec(1, 1, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0, 1);
        addVec(1, 1, 0, 0, 0, 0, 1,   1, 127, 100, 1, 0, 0);
        addVec(1, 1, 0, 0, 0, 0, 1,   0, 0, 0, 2, 0, 0);
        // Back-to-back 2x2 windows: 4*127*127 saturates, then 4*(-5*3)=-60 clamps to 0
        addVec(1, 1, 1, 127, 127, 0, 1, 0, 0, 0, 2, 0, 1);
        addVec(1, 1, 1, 127, 127, 0, 1, 0, 0, 0, 2, 0, 1);
        addVec(1, 1, 1, 127, 127, 0, 1, 0, 0, 0, 2, 0, 1);
        addVec(1, 1, 1, 127, 127, 0, 1, 0, 0, 0, 2, 0, 1);
        addVec(1, 1, 1, -5, 3, 0, 1,  0, 0, 0, 2, 0, 1);
        addVec(1, 1, 1, -5, 3, 0, 1,  1, 127, 127, 2, 0, 1);
        addVec(1, 1, 1, -5, 3, 0, 1,  0, 0, 0, 3, 0, 1);
        addVec(1, 1, 1, -5, 3, 0, 1,  0, 0, 0, 3, 0, 1);
        addVec(1, 1, 0, 0, 0, 0, 1,   0, 0, 0, 3, 0, 1);
        addVec(1, 1, 0, 0, 0, 0, 1,   1, 0, 0, 3, 0, 0);
        addVec(1, 1, 0, 0, 0, 0, 1,   0, 0, 0, 4, 0, 0);
        // Negative bias: 100-50 = 50, 12 after >>>2
        addVec(1, 0, 1, 10, 10, -50, 0, 0, 0, 0, 4, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 4, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 0,   1, 50, 12, 4, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 5, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rstN, vecs[i].fw, vecs[i].acEn, int'(vecs[i].n),
                          int'(vecs[i].w), int'(vecs[i].b), vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].exp0,
                        vecs[i].exp2, vecs[i].expCount, vecs[i].expOvf, vecs[i].expBusy);
        end

        // Two back-to-back 1x1 windows while stalled: second result is dropped.
        step("drop.tap1", 1, 0, 1, 3, 4, 0, 0,  0, 0, 0, 5, 0, 1);
        step("drop.tap2", 1, 0, 1, 2, 2, 0, 0,  0, 0, 0, 5, 0, 1);
        step("drop.first", 1, 0, 0, 0, 0, 0, 0, 1, 12, 3, 5, 0, 1);
        step("drop.second", 1, 0, 0, 0, 0, 0, 0, 1, 12, 3, 5, 1, 0);
        step("drop.accept", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6, 1, 0);
        step("drop.idle", 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6, 1, 0);

        // Transfer and new completion on the same edge: valid stays high with new data.
        step("swap.tap1", 1, 0, 1, 5, 5, 0, 1,  0, 0, 0, 6, 1, 1);
        step("swap.tap2", 1, 0, 1, 2, 2, 0, 1,  0, 0, 0, 6, 1, 1);
        step("swap.first", 1, 0, 0, 0, 0, 0, 1, 1, 25, 6, 6, 1, 1);
        step("swap.second", 1, 0, 0, 0, 0, 0, 1, 1, 4, 1, 7, 1, 0);
        step("swap.drain", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8, 1, 0);

        // Reset after two of four taps discards the partial window.
        step("rst.tap1", 1, 1, 1, 1, 1, 0, 0,   0, 0, 0, 8, 1, 1);
        step("rst.tap2", 1, 1, 1, 1, 1, 0, 0,   0, 0, 0, 8, 1, 1);
        step("rst.apply", 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        step("rst.win1", 1, 1, 1, 1, 1, 99, 0,  0, 0, 0, 0, 0, 1);
        step("rst.win2", 1, 1, 1, 1, 1, 99, 0,  0, 0, 0, 0, 0, 1);
        step("rst.win3", 1, 1, 1, 1, 1, 99, 0,  0, 0, 0, 0, 0, 1);
        step("rst.win4", 1, 1, 1, 1, 1, 5, 0,   0, 0, 0, 0, 0, 1);
        step("rst.lat1", 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
        step("rst.result", 1, 1, 0, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0);
        step("rst.accept", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);

        // Window size latched on the first tap; later filter_width_i changes wait.
        step("fw.tap1", 1, 1, 1, 2, 3, 0, 0,   0, 0, 0, 1, 0, 1);
        step("fw.tap2", 1, 0, 1, 2, 3, 0, 0,   0, 0, 0, 1, 0, 1);
        step("fw.tap3", 1, 0, 1, 2, 3, 0, 0,   0, 0, 0, 1, 0, 1);
        step("fw.tap4", 1, 0, 1, 2, 3, 0, 0,   0, 0, 0, 1, 0, 1);
        step("fw.lat1", 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1);
        step("fw.result", 1, 0, 0, 0, 0, 0, 0, 1, 24, 6, 1, 0, 0);
        step("fw.accept", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0);
        step("fw.k1tap", 1, 0, 1, 7, 3, 0, 0,  0, 0, 0, 2, 0, 1);
        step("fw.k1lat", 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 1);
        step("fw.k1res", 1, 0, 0, 0, 0, 0, 0,  1, 21, 5, 2, 0, 0);
        step("fw.k1acc", 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
